// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if: bundles the requester handshakes and the VRAM command/return bus
// of the VRAM arbiter.
//   display fetch : disp_req, disp_addr[14:0] -> disp_ack, disp_rvalid
//   sprite fetch  : spr_req,  spr_addr[14:0]  -> spr_ack,  spr_rvalid
//   cpu data port : cpu_req, cpu_we, cpu_addr[16:0], cpu_wdata[7:0]
//                   -> cpu_ack, cpu_rvalid, cpu_rdata[7:0]
//   shared return : rd_data[31:0]
//   vram          : ram_addr[14:0], ram_we, ram_be[3:0], ram_wdata[31:0] <- ram_rdata[31:0]
// Modport slave is taken by the arbiter; master by whoever drives requests and models the RAM.
interface vram_arbiter_if;
    logic        disp_req;
    logic [14:0] disp_addr;
    logic        disp_ack;
    logic        disp_rvalid;

    logic        spr_req;
    logic [14:0] spr_addr;
    logic        spr_ack;
    logic        spr_rvalid;

    logic [31:0] rd_data;

    logic        cpu_req;
    logic        cpu_we;
    logic [16:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack;
    logic        cpu_rvalid;
    logic [7:0]  cpu_rdata;

    logic [14:0] ram_addr;
    logic        ram_we;
    logic [3:0]  ram_be;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    modport slave (
        input  disp_req, disp_addr, spr_req, spr_addr,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
        output disp_ack, disp_rvalid, spr_ack, spr_rvalid, rd_data,
        output cpu_ack, cpu_rvalid, cpu_rdata,
        output ram_addr, ram_we, ram_be, ram_wdata
    );

    modport master (
        output disp_req, disp_addr, spr_req, spr_addr,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
        input  disp_ack, disp_rvalid, spr_ack, spr_rvalid, rd_data,
        input  cpu_ack, cpu_rvalid, cpu_rdata,
        input  ram_addr, ram_we, ram_be, ram_wdata
    );
endinterface

// File: rtl/vram_arbiter.sv
// vram_arbiter: single-port VRAM access arbiter for display fetch, sprite fetch and CPU.
// Fixed priority display > sprite > CPU; a requester whose ack is high this cycle is not
// eligible, so no requester is granted on consecutive cycles. The winner of cycle N sees
// its ack and the registered RAM command in N+1; read data returns in N+2 with rvalid.
// Ports:
//   clk25 - 25 MHz system clock
//   rst   - asynchronous active-high reset
//   bus   - vram_arbiter_if.slave (requester handshakes, read return, RAM command bus)
// Parameter STARVE_LIMIT (1..15): losing cycles before a waiting CPU overrides priority.
// Optional feature macro: VRAM_ARB_STARVE_GUARD_EN enables the CPU anti-starvation guard;
// without it priority is strict and the CPU may starve.
module vram_arbiter #(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input logic           clk25,
    input logic           rst,
    vram_arbiter_if.slave bus
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : gen_bad_limit
        $error("vram_arbiter: STARVE_LIMIT must be within 1..15");
    end

    // Registered grant pulses and RAM command
    logic        disp_ack_q, spr_ack_q, cpu_ack_q;
    logic [14:0] ram_addr_q, ram_addr_d;
    logic        ram_we_q, ram_we_d;
    logic [3:0]  ram_be_q, ram_be_d;
    logic [31:0] ram_wdata_q, ram_wdata_d;

    // Read tags: stage 1 travels with the command, stage 2 lines up with ram_rdata
    logic        rd1_disp_q, rd1_spr_q, rd1_cpu_q;
    logic [1:0]  lane1_q, lane1_d;
    logic        rd2_disp_q, rd2_spr_q, rd2_cpu_q;
    logic [1:0]  lane2_q;

    logic disp_el, spr_el, cpu_el;
    logic win_disp, win_spr, win_cpu;

    // An ack in flight masks the request of the same requester
    assign disp_el = bus.disp_req & ~disp_ack_q;
    assign spr_el  = bus.spr_req  & ~spr_ack_q;
    assign cpu_el  = bus.cpu_req  & ~cpu_ack_q;

`ifdef VRAM_ARB_STARVE_GUARD_EN
    localparam logic [3:0] Limit = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt_q, starve_cnt_d;
    logic       starve_hit;

    assign starve_hit = cpu_el && (starve_cnt_q >= Limit);

    always_comb begin
        win_disp = disp_el & ~starve_hit;
        win_spr  = spr_el & ~disp_el & ~starve_hit;
        win_cpu  = cpu_el & (starve_hit | (~disp_el & ~spr_el));
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!bus.cpu_req || win_cpu) begin
            starve_cnt_d = '0;
        end else if (cpu_el && (starve_cnt_q < Limit)) begin
            // Eligible but lost this cycle
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    always_comb begin
        win_disp = disp_el;
        win_spr  = spr_el & ~disp_el;
        win_cpu  = cpu_el & ~disp_el & ~spr_el;
    end
`endif

    // Next RAM command; address and write data hold when nobody wins
    always_comb begin
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_we_d    = 1'b0;
        ram_be_d    = 4'b0000;
        lane1_d     = lane1_q;
        if (win_disp) begin
            ram_addr_d = bus.disp_addr;
        end else if (win_spr) begin
            ram_addr_d = bus.spr_addr;
        end else if (win_cpu) begin
            ram_addr_d = bus.cpu_addr[16:2];
            lane1_d    = bus.cpu_addr[1:0];
            if (bus.cpu_we) begin
                ram_we_d    = 1'b1;
                ram_be_d    = 4'b0001 << bus.cpu_addr[1:0];
                ram_wdata_d = {4{bus.cpu_wdata}};
            end
        end
    end

    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            disp_ack_q  <= 1'b0;
            spr_ack_q   <= 1'b0;
            cpu_ack_q   <= 1'b0;
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_be_q    <= '0;
            ram_wdata_q <= '0;
            rd1_disp_q  <= 1'b0;
            rd1_spr_q   <= 1'b0;
            rd1_cpu_q   <= 1'b0;
            lane1_q     <= '0;
            rd2_disp_q  <= 1'b0;
            rd2_spr_q   <= 1'b0;
            rd2_cpu_q   <= 1'b0;
            lane2_q     <= '0;
        end else begin
            disp_ack_q  <= win_disp;
            spr_ack_q   <= win_spr;
            cpu_ack_q   <= win_cpu;
            ram_addr_q  <= ram_addr_d;
            ram_we_q    <= ram_we_d;
            ram_be_q    <= ram_be_d;
            ram_wdata_q <= ram_wdata_d;
            rd1_disp_q  <= win_disp;
            rd1_spr_q   <= win_spr;
            rd1_cpu_q   <= win_cpu & ~bus.cpu_we;
            lane1_q     <= lane1_d;
            rd2_disp_q  <= rd1_disp_q;
            rd2_spr_q   <= rd1_spr_q;
            rd2_cpu_q   <= rd1_cpu_q;
            lane2_q     <= lane1_q;
        end
    end

    assign bus.disp_ack    = disp_ack_q;
    assign bus.spr_ack     = spr_ack_q;
    assign bus.cpu_ack     = cpu_ack_q;
    assign bus.disp_rvalid = rd2_disp_q;
    assign bus.spr_rvalid  = rd2_spr_q;
    assign bus.cpu_rvalid  = rd2_cpu_q;
    assign bus.rd_data     = bus.ram_rdata;
    // Gated so the byte port reads 0 outside a CPU return (and during reset)
    assign bus.cpu_rdata   = rd2_cpu_q ? bus.ram_rdata[{lane2_q, 3'b000} +: 8] : 8'h00;
    assign bus.ram_addr    = ram_addr_q;
    assign bus.ram_we      = ram_we_q;
    assign bus.ram_be      = ram_be_q;
    assign bus.ram_wdata   = ram_wdata_q;

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Single-port VRAM access arbiter between the host bus data-port logic (CPU), the layer/display fetch unit and the sprite fetch unit. Sits between the requesters and the 128 KB, 32-bit-wide video RAM. Grants at most one access per clock, registers the RAM command, and returns read data with a fixed latency. Fixed priority with an optional CPU anti-starvation guard.

## Interface
- `STARVE_LIMIT`, default 8: consecutive losing cycles after which a pending CPU request overrides priority (1..15).
- `clk25`  in  1  system clock, 25 MHz.
- `rst`  in  1  asynchronous, active-high reset.
- `disp_req`  in  1  display fetch request, level.
- `disp_addr`  in  15  display word address.
- `disp_ack`  out  1  one-cycle grant pulse.
- `disp_rvalid`  out  1  `rd_data` valid for display.
- `spr_req` / `spr_addr[14:0]` / `spr_ack` / `spr_rvalid`: same as display, for sprite fetch.
- `rd_data`  out  32  shared read data, equal to `ram_rdata`.
- `cpu_req`  in  1  CPU request, level.
- `cpu_we`  in  1  1 = byte write, 0 = byte read.
- `cpu_addr`  in  17  CPU byte address.
- `cpu_wdata`  in  8  write byte.
- `cpu_ack`  out  1  one-cycle grant pulse.
- `cpu_rvalid`  out  1  `cpu_rdata` valid (reads only).
- `cpu_rdata`  out  8  selected read byte.
- `ram_addr`  out  15  RAM word address.
- `ram_we`  out  1  RAM write strobe.
- `ram_be`  out  4  byte enables for writes.
- `ram_wdata`  out  32  RAM write data.
- `ram_rdata`  in  32  RAM read data, one cycle after address.

## Operation
- Each cycle, eligible requester = `req` high AND its `ack` not high this cycle (ack masks req: no back-to-back grant to the same requester).
- Priority: display > sprite > CPU. Winner sampled in cycle N.
- Cycle N+1 (registered): winner's `ack`=1; `ram_addr`, `ram_we`, `ram_be`, `ram_wdata` driven for the winner.
- Fetch grant: `ram_addr` = requester addr, `ram_we`=0, `ram_be`=0.
- CPU grant: `ram_addr` = `cpu_addr[16:2]`. Write: `ram_we`=1, `ram_be` = one-hot of `cpu_addr[1:0]` (00→0001 … 11→1000), `ram_wdata` = `{4{cpu_wdata}}`. Read: `ram_we`=0, lane `cpu_addr[1:0]` latched.
- Read return in cycle N+2: matching `*_rvalid`=1 for one cycle; `rd_data`=`ram_rdata`; `cpu_rdata` = `ram_rdata[8*lane+7:8*lane]`. CPU writes produce no `cpu_rvalid`.
- No winner: `ram_we`=0, `ram_be`=0, `ram_addr`/`ram_wdata` hold.
- Requester must present stable addr/data while `req` is high and until its `ack`. It may change addr or drop `req` in the ack cycle.
- Reset values: all `*_ack`, `*_rvalid`, `ram_we` 0; `ram_be`, `ram_addr`, `ram_wdata`, `cpu_rdata` 0; starve counter 0; in-flight read tags cleared.
- Reset mid-operation: pending returns are discarded and no `rvalid` fires after reset release.

## Timing
- Request to ack: 1 cycle when winning. Request to read data: 2 cycles.
- Peak throughput: one RAM access per cycle. Per requester: one per 2 cycles (ack masking).
- Simultaneous display+sprite+CPU requests: display N, sprite N+1, display N+2 (if still requesting), and so on. The CPU waits unless the guard is enabled.
- Pipelined reads from different requesters overlap. `rvalid` order always equals grant order.

## Configuration
- `VRAM_ARB_STARVE_GUARD_EN` defined:
  - A 4-bit counter increments each cycle the CPU is eligible but loses, saturating at `STARVE_LIMIT`.
  - At `STARVE_LIMIT`, an eligible CPU wins over all requesters.
  - The counter clears on a CPU grant or when `cpu_req` drops.
- Not defined: strict priority, no counter logic, and the CPU may starve indefinitely.

## Test plan
- Reset: assert `rst` mid-read (grant at N, `rst` at N+1). Required: all outputs 0 immediately; no `disp_rvalid` after release.
- CPU write: `cpu_addr`=0x00006, `cpu_wdata`=0xA5. Required: one cycle later `ram_addr`=0x0001, `ram_be`=0100, `ram_wdata`=0xA5A5A5A5, `cpu_ack`=1.
- CPU read of the same byte (RAM model returns 0x00A50000). Required: `cpu_rvalid`=1 two cycles after request, `cpu_rdata`=0xA5.
- Display and sprite requesting continuously. Required: acks alternate display/sprite every cycle; `rd_data` matches RAM model words; `rvalid` order equals grant order.
- All three requesting continuously, `STARVE_LIMIT`=8:
  - Guard on: `cpu_ack` within 9 cycles of `cpu_req`.
  - Guard off: `cpu_ack` never occurs over 100 cycles.
- Single display request held: `disp_ack` every 2nd cycle, `ram_addr` follows `disp_addr` updated on each ack.
